// File: rtl/matrix_result_unloader.sv
// Streams a captured 3x3 result matrix out one element per transfer with
// valid/ready handshaking, index tagging and a sticky overrun flag.
module matrix_result_unloader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [DATA_W-1:0] M0_in,
    input  logic [DATA_W-1:0] M1_in,
    input  logic [DATA_W-1:0] M2_in,
    input  logic [DATA_W-1:0] M3_in,
    input  logic [DATA_W-1:0] M4_in,
    input  logic [DATA_W-1:0] M5_in,
    input  logic [DATA_W-1:0] M6_in,
    input  logic [DATA_W-1:0] M7_in,
    input  logic [DATA_W-1:0] M8_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
    localparam logic [3:0] LAST_IDX = 4'd8;

    logic [0:0]        state;
    logic [3:0]        idx_p0;
    logic              ovr_p0;
    logic [DATA_W-1:0] mat_p0 [0:8];

    logic xfer;
    logic last_xfer;
    logic capture;

    assign xfer      = (state == STREAM) && out_ready;
    assign last_xfer = xfer && (idx_p0 == LAST_IDX);
    // A done coinciding with the final transfer chains the next matrix with no gap.
    assign capture   = done && ((state == IDLE) || last_xfer);

    // Control: state, element index and sticky overrun
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            idx_p0 <= 4'd0;
            ovr_p0 <= 1'b0;
        end else begin
            if (capture) begin
                state  <= STREAM;
                idx_p0 <= 4'd0;
            end else if (last_xfer) begin
                state  <= IDLE;
                idx_p0 <= 4'd0;
            end else if (xfer) begin
                idx_p0 <= idx_p0 + 4'd1;
            end
            if (done && (state == STREAM) && !last_xfer)
                ovr_p0 <= 1'b1;
        end
    end

    // Data: matrix buffer, loaded only on an accepted done
    always_ff @(posedge clk) begin
        if (capture) begin
            mat_p0[0] <= M0_in;
            mat_p0[1] <= M1_in;
            mat_p0[2] <= M2_in;
            mat_p0[3] <= M3_in;
            mat_p0[4] <= M4_in;
            mat_p0[5] <= M5_in;
            mat_p0[6] <= M6_in;
            mat_p0[7] <= M7_in;
            mat_p0[8] <= M8_in;
        end
    end

    // Output stage: data forced to zero when nothing is being presented
    always_comb begin
        out_valid = (state == STREAM);
        busy      = out_valid;
        out_idx   = out_valid ? idx_p0 : 4'd0;
        out_last  = out_valid && (idx_p0 == LAST_IDX);
        overrun   = ovr_p0;
        out_data  = '0;
        if (out_valid && (idx_p0 <= LAST_IDX))
            out_data = mat_p0[idx_p0];
    end

endmodule
